clock_reset_sequencer: RTL and testbench

- Per-domain reset sequencer that sits directly upstream of the fixed-clock broadcast node in the clock graph.
- Converts the raw asynchronous active-low domain reset into a synchronized, stretched, active-high reset plus a clock-enable, and drives the broadcast node's input reset.
- Also services a software-requested domain reset through a four-phase req/ack handshake.

---
 rtl/reset_seq_pkg.sv | 16 +
 rtl/reset_seq_sync.sv | 23 ++
 rtl/clock_reset_sequencer.sv | 153 +++++++++++++++
 tb/tb_clock_reset_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the per-domain clock/reset sequencer.
package reset_seq_pkg;

   localparam int SYNC_STAGES_DEF    = 3;
   localparam int STRETCH_CYCLES_DEF = 16;
   localparam int EVT_W              = 8;

   typedef enum logic [2:0] {
      HOLD   = 3'd0,
      CLK_ON = 3'd1,
      RUN    = 3'd2,
      SW_RST = 3'd3,
      ACK    = 3'd4
   } state_e;

endpackage

// File: rtl/reset_seq_sync.sv
// Reset-release synchronizer: asserts immediately, releases SYNC_STAGES edges later.
module reset_seq_sync #(
   parameter int SYNC_STAGES = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic synced_o
);

   logic [SYNC_STAGES-1:0] chain_q;

   // shift a constant 1 in once the raw reset has released
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign synced_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// Per-domain reset sequencer: synchronized, stretched reset, clock enable and sw reset handshake.
// Optional macro RESET_SEQ_EVENT_COUNT_EN adds a saturating sw-reset event counter port.
module clock_reset_sequencer #(
   parameter int SYNC_STAGES    = reset_seq_pkg::SYNC_STAGES_DEF,
   parameter int STRETCH_CYCLES = reset_seq_pkg::STRETCH_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic sw_reset_req,
   output logic sw_reset_ack,
   output logic auto_out_clock_en,
   output logic auto_out_reset,
   output logic reset_done
`ifdef RESET_SEQ_EVENT_COUNT_EN
   ,
   output logic [reset_seq_pkg::EVT_W-1:0] reset_events
`endif
);

   import reset_seq_pkg::*;

   localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             synced_s;
   logic             en_q, rst_q, done_q, ack_q;
   logic             en_d, rst_d, done_d, ack_d;

   reset_seq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i    (clock),
      .rst_ni   (reset),
      .synced_o (synced_s)
   );

   // state, counter and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         rst_q   <= 1'b1;
         done_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         ack_q   <= ack_d;
      end
   end

   // next-state and stretch counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         HOLD: begin
            if (synced_s) begin
               state_d = CLK_ON;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = HOLD;
            end
         end
         CLK_ON, SW_RST: begin
            if (cnt_q == '0) begin
               state_d = (state_q == CLK_ON) ? RUN : ACK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RUN: begin
            if (sw_reset_req) begin
               state_d = SW_RST;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = RUN;
            end
         end
         // leaving ACK only on req low is what makes the handshake four-phase
         ACK: begin
            if (!sw_reset_req) begin
               state_d = RUN;
            end else begin
               state_d = ACK;
            end
         end
         default: begin
            state_d = HOLD;
            cnt_d   = '0;
         end
      endcase
   end

   // Moore output decode of the upcoming state, registered above
   always_comb begin
      en_d   = 1'b0;
      rst_d  = 1'b1;
      done_d = 1'b0;
      ack_d  = 1'b0;
      case (state_d)
         HOLD: begin
            en_d = 1'b0;
         end
         CLK_ON, SW_RST: begin
            en_d = 1'b1;
         end
         RUN: begin
            en_d   = 1'b1;
            rst_d  = 1'b0;
            done_d = 1'b1;
         end
         ACK: begin
            en_d   = 1'b1;
            rst_d  = 1'b0;
            done_d = 1'b1;
            ack_d  = 1'b1;
         end
         default: begin
            en_d = 1'b0;
         end
      endcase
   end

   assign auto_out_clock_en = en_q;
   assign auto_out_reset    = rst_q;
   assign reset_done        = done_q;
   assign sw_reset_ack      = ack_q;

`ifdef RESET_SEQ_EVENT_COUNT_EN
   logic [EVT_W-1:0] events_q;

   // count entries into SW_RST, saturating
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         events_q <= '0;
      end else if (state_q == RUN && state_d == SW_RST && events_q != {EVT_W{1'b1}}) begin
         events_q <= events_q + EVT_W'(1);
      end else begin
         events_q <= events_q;
      end
   end

   assign reset_events = events_q;
`endif

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed self-checking bench for clock_reset_sequencer (default and STRETCH_CYCLES=1 builds).
module tb_clock_reset_sequencer;

   // expected output vectors {en, reset, done, ack}
   localparam logic [3:0] V_HOLD = 4'b0100;
   localparam logic [3:0] V_STR  = 4'b1100;
   localparam logic [3:0] V_RUN  = 4'b1010;
   localparam logic [3:0] V_ACK  = 4'b1011;

   logic clk;
   logic rst_n;
   logic req;
   logic req2;
   logic ack, en, rst_o, done;
   logic ack2, en2, rst2, done2;
   int   n_total;
   int   n_bad;

`ifdef RESET_SEQ_EVENT_COUNT_EN
   logic [7:0] ev;
   logic [7:0] ev2;
`endif

   clock_reset_sequencer dut (
      .clock             (clk),
      .reset             (rst_n),
      .sw_reset_req      (req),
      .sw_reset_ack      (ack),
      .auto_out_clock_en (en),
      .auto_out_reset    (rst_o),
      .reset_done        (done)
`ifdef RESET_SEQ_EVENT_COUNT_EN
      ,
      .reset_events      (ev)
`endif
   );

   clock_reset_sequencer #(
      .SYNC_STAGES    (2),
      .STRETCH_CYCLES (1)
   ) dut_min (
      .clock             (clk),
      .reset             (rst_n),
      .sw_reset_req      (req2),
      .sw_reset_ack      (ack2),
      .auto_out_clock_en (en2),
      .auto_out_reset    (rst2),
      .reset_done        (done2)
`ifdef RESET_SEQ_EVENT_COUNT_EN
      ,
      .reset_events      (ev2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step_chk(input string tag, input int e, input logic [3:0] exp);
      @(posedge clk);
      @(negedge clk);
      check_val($sformatf("%s@%0d", tag, e), {28'd0, en, rst_o, done, ack}, {28'd0, exp});
   endtask

   task automatic step_chk2(input string tag, input int e, input logic [3:0] exp);
      @(posedge clk);
      @(negedge clk);
      check_val($sformatf("%s@%0d", tag, e), {28'd0, en2, rst2, done2, ack2}, {28'd0, exp});
   endtask

   // release at a negedge, then check the 20 edges of the default power-on sequence
   task automatic power_on(input string tag);
      rst_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         step_chk(tag, e, (e >= 20) ? V_RUN : ((e >= 4) ? V_STR : V_HOLD));
      end
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      req     = 1'b0;
      req2    = 1'b0;

      // power-on with defaults
      repeat (5) @(negedge clk);
      check_val("rst_state", {28'd0, en, rst_o, done, ack}, {28'd0, V_HOLD});
      power_on("pwr");

      // software reset with req held through ACK
      req = 1'b1;
      for (int e = 1; e <= 16; e++) step_chk("sw", e, V_STR);
      step_chk("sw_ack", 17, V_ACK);
      step_chk("sw_ack_hold", 18, V_ACK);
      req = 1'b0;
      step_chk("sw_ret", 19, V_RUN);
      step_chk("sw_idle", 20, V_RUN);

      // req dropped during SW_RST: one-cycle ack then RUN
      req = 1'b1;
      step_chk("drop", 1, V_STR);
      req = 1'b0;
      for (int e = 2; e <= 16; e++) step_chk("drop", e, V_STR);
      step_chk("drop_ack", 17, V_ACK);
      step_chk("drop_ret", 18, V_RUN);

      // early request held from reset through release
      rst_n = 1'b0;
      req   = 1'b1;
      repeat (3) @(negedge clk);
      power_on("early");
      for (int e = 21; e <= 36; e++) step_chk("early_sw", e, V_STR);
      for (int e = 37; e <= 46; e++) step_chk("early_ack", e, V_ACK);
      req = 1'b0;
      for (int e = 47; e <= 49; e++) step_chk("early_ret", e, V_RUN);

      // mid-sequence async reset at cycle 8 of SW_RST
      req = 1'b1;
      for (int e = 1; e <= 8; e++) step_chk("mid", e, V_STR);
      req = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_val("mid_async", {28'd0, en, rst_o, done, ack}, {28'd0, V_HOLD});
      @(negedge clk);
      power_on("mid_rep");

      // minimal instance: SYNC_STAGES=2, STRETCH_CYCLES=1
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_val("min_rst", {28'd0, en2, rst2, done2, ack2}, {28'd0, V_HOLD});
      rst_n = 1'b1;
      step_chk2("min_pwr", 1, V_HOLD);
      step_chk2("min_pwr", 2, V_HOLD);
      step_chk2("min_pwr", 3, V_STR);
      step_chk2("min_pwr", 4, V_RUN);
      req2 = 1'b1;
      step_chk2("min_sw", 1, V_STR);
      step_chk2("min_sw", 2, V_ACK);
      req2 = 1'b0;
      step_chk2("min_sw", 3, V_RUN);

`ifdef RESET_SEQ_EVENT_COUNT_EN
      // dut has been in RUN since its own power-on; start the counter from a clean reset
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_val("ev_clr0", {24'd0, ev}, 32'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      for (int k = 1; k <= 260; k++) begin
         int budget;
         req    = 1'b1;
         budget = 0;
         while (ack !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget++;
         end
         if (budget >= 40) check_val("ev_ack_timeout", {31'd0, ack}, 32'd1);
         req = 1'b0;
         @(negedge clk);
         if (k == 1) check_val("ev_first", {24'd0, ev}, 32'd1);
         if (k == 254) check_val("ev_254", {24'd0, ev}, 32'd254);
      end
      check_val("ev_sat", {24'd0, ev}, 32'd255);
      rst_n = 1'b0;
      #1 check_val("ev_clr", {24'd0, ev}, 32'd0);
      @(negedge clk);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
